// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared select encoding, slot state and default width for rr_mux_arbiter
package mux_arb_pkg;
    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;
    localparam int WIDTH_DEF = 4;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin grant from valids, with the last-winner pointer
module rr_arb2
    import mux_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a_valid,
    input  logic b_valid,
    input  logic accept,
    output logic grant_a,
    output logic grant_b
);
    logic last;
    always_comb begin
        grant_a = a_valid & (!b_valid | (last == SEL_B));
        grant_b = b_valid & (!a_valid | (last == SEL_A));
    end
    // the pointer only moves when the grant is actually taken, so stalls keep priority
    always_ff @(posedge clk) begin
        if (rst) last <= SEL_B;
        else if (accept) last <= grant_a ? SEL_A : SEL_B;
    end
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin A/B valid/ready arbiter with registered slot; ARB_STATS_EN adds grant counters
module rr_mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    output logic             y_sel,
`ifdef ARB_STATS_EN
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
`endif
    input  logic             y_ready
);
    slot_t state, state_n;
    logic grant_a, grant_b, load, take;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .accept  (take),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else state <= state_n;
    end

    always_comb begin
        state_n = take ? FULL : (y_ready ? EMPTY : state);
    end

    // readies are masked during reset so no word is taken while the slot is being cleared
    always_comb begin
        y_valid = (state == FULL);
        load    = !y_valid | y_ready;
        a_ready = !rst & load & grant_a;
        b_ready = !rst & load & grant_b;
        take    = a_ready | b_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_data <= '0;
            y_sel  <= SEL_B;
        end else if (take) begin
            y_data <= a_ready ? a_data : b_data;
            y_sel  <= a_ready ? SEL_A : SEL_B;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (a_ready && !(&cnt_a)) cnt_a <= cnt_a + 1'b1;
            if (b_ready && !(&cnt_b)) cnt_b <= cnt_b + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed vector table plus reset/counter sequences for rr_mux_arbiter
module tb_rr_mux_arbiter;
    logic clk = 0, rst = 1;
    logic a_valid = 0, b_valid = 0, y_ready = 0;
    logic [3:0] a_data = 0, b_data = 0;
    logic a_ready, b_ready, y_valid, y_sel;
    logic [3:0] y_data;
`ifdef ARB_STATS_EN
    logic [1:0] cnt_a, cnt_b;
`endif
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.WIDTH(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .y_valid(y_valid), .y_data(y_data), .y_sel(y_sel),
`ifdef ARB_STATS_EN
        .cnt_a(cnt_a), .cnt_b(cnt_b),
`endif
        .y_ready(y_ready)
    );

    typedef struct {
        logic av; logic [3:0] ad; logic bv; logic [3:0] bd; logic yr;
        logic ea; logic eb; logic ev; logic [3:0] ed; logic es;
    } vec_t;
    vec_t vecs [15];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [3:0] ad, input logic bv, input logic [3:0] bd, input logic yr);
        a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr;
    endtask

    initial begin
        //          av ad    bv bd    yr  ea eb  ev ed    es
        vecs[0]  = '{1, 4'h3, 1, 4'hC, 1, 1, 0, 1, 4'h3, 1};
        vecs[1]  = '{1, 4'h3, 1, 4'hC, 1, 0, 1, 1, 4'hC, 0};
        vecs[2]  = '{1, 4'h3, 1, 4'hC, 1, 1, 0, 1, 4'h3, 1};
        vecs[3]  = '{1, 4'h3, 1, 4'hC, 1, 0, 1, 1, 4'hC, 0};
        vecs[4]  = '{1, 4'h9, 0, 4'h0, 1, 1, 0, 1, 4'h9, 1};
        vecs[5]  = '{1, 4'h5, 0, 4'h0, 1, 1, 0, 1, 4'h5, 1};
        vecs[6]  = '{0, 4'h0, 1, 4'h6, 0, 0, 0, 1, 4'h5, 1};
        vecs[7]  = '{0, 4'h0, 1, 4'h6, 0, 0, 0, 1, 4'h5, 1};
        vecs[8]  = '{0, 4'h0, 1, 4'h6, 0, 0, 0, 1, 4'h5, 1};
        vecs[9]  = '{0, 4'h0, 1, 4'h6, 1, 0, 1, 1, 4'h6, 0};
        vecs[10] = '{0, 4'h0, 0, 4'h0, 1, 0, 0, 0, 4'h6, 0};
        vecs[11] = '{0, 4'h0, 0, 4'h0, 1, 0, 0, 0, 4'h6, 0};
        vecs[12] = '{1, 4'h7, 1, 4'hA, 0, 1, 0, 1, 4'h7, 1};
        vecs[13] = '{1, 4'h7, 1, 4'hA, 0, 0, 0, 1, 4'h7, 1};
        vecs[14] = '{1, 4'h7, 1, 4'hA, 1, 0, 1, 1, 4'hA, 0};

        // reset held two cycles with both sources offering
        drive(1, 4'h3, 1, 4'hC, 1);
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_a_ready", a_ready, 0);
            chk("rst_b_ready", b_ready, 0);
        end
        @(posedge clk); #1;
        chk("rst_y_valid", y_valid, 0);
        chk("rst_y_data", y_data, 0);
        chk("rst_y_sel", y_sel, 0);
        rst = 0;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd, vecs[i].yr);
            #1;
            chk($sformatf("v%0d_a_ready", i), a_ready, vecs[i].ea);
            chk($sformatf("v%0d_b_ready", i), b_ready, vecs[i].eb);
            @(posedge clk); #1;
            chk($sformatf("v%0d_y_valid", i), y_valid, vecs[i].ev);
            chk($sformatf("v%0d_y_data", i), y_data, vecs[i].ed);
            chk($sformatf("v%0d_y_sel", i), y_sel, vecs[i].es);
        end

        // reset while the slot is full drops the word and restores A priority
        drive(1, 4'h2, 0, 4'h0, 0);
        rst = 1;
        #1;
        chk("midrst_a_ready", a_ready, 0);
        @(posedge clk); #1;
        chk("midrst_y_valid", y_valid, 0);
        chk("midrst_y_data", y_data, 0);
        chk("midrst_y_sel", y_sel, 0);
        rst = 0;
        drive(1, 4'h1, 1, 4'hE, 1);
        #1;
        chk("post_rst_a_first", a_ready, 1);
        chk("post_rst_b_wait", b_ready, 0);
        @(posedge clk); #1;
        chk("post_rst_y_data", y_data, 4'h1);

`ifdef ARB_STATS_EN
        drive(0, 0, 0, 0, 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        drive(1, 4'h4, 0, 4'h0, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("cnt_a_%0d", i), cnt_a, (i < 3) ? i + 1 : 3);
            chk($sformatf("cnt_b_%0d", i), cnt_b, 0);
        end
        rst = 1;
        @(posedge clk); #1;
        chk("cnt_a_rst", cnt_a, 0);
        rst = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
